// File: rtl/ifu_fetch.sv
// PC register and instruction-fetch sequencer: issues req/gnt/rvalid fetches at pc_out,
// presents the word to decode, and advances to the next-PC unit's result on release.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_in,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_MISALGN = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [1:0]         code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               err_q, err_d;
  logic               load_s;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  // Next-state, next-PC and fetch-datapath decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // A grant coinciding with a flush is deliberately dropped.
        if (flush) begin
          pc_d   = flush_pc;
          load_s = 1'b1;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (flush) begin
          pc_d    = flush_pc;
          load_s  = 1'b1;
          state_d = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          state_d = S_ERR;
          code_d  = CODE_TIMEOUT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (flush) begin
          pc_d   = flush_pc;
          load_s = 1'b1;
        end else begin
          pc_d = pc_q;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          state_d = S_ERR;
          code_d  = CODE_TIMEOUT;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_d    = flush_pc;
          load_s  = 1'b1;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (stall) begin
          state_d = S_HOLD;
        end else begin
          pc_d    = npc_in;
          load_s  = 1'b1;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_ERR: begin
        valid_d = 1'b0;
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // A misaligned target still loads, but no fetch is ever issued for it.
    if (load_s && pc_misaligned(pc_d)) begin
      state_d = S_ERR;
      code_d  = CODE_MISALGN;
      valid_d = 1'b0;
    end else begin
      code_d = code_d;
    end
  end

  // Output flags follow the next state so they are registered alongside it
  always_comb begin
    req_d = (state_d == S_REQ);
    err_d = (state_d == S_ERR);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      code_q  <= CODE_NONE;
      cnt_q   <= {CNT_W{1'b0}};
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign err         = err_q;
  assign err_code    = code_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- PC register and instruction-fetch sequencer. It is the consumer side of the next-PC unit.
- Holds the architectural PC and drives it to the next-PC unit and to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched word to decode. When decode releases it, loads the next-PC unit's result.
- Supports stall, flush-redirect, misalignment trap and memory timeout.

Parameters:
- RESET_PC, 32'h00003000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles from grant to rvalid before a timeout error.
- CNT_W, 5, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- npc_in  input  32  next PC from the next-PC unit; combinational function of pc_out.
- stall  input  1  decode not ready; hold the current instruction.
- flush  input  1  redirect request; overrides stall.
- flush_pc  input  32  redirect target, sampled when flush=1.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; always equals pc_out.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- pc_out  output  32  current PC, to the next-PC unit and to decode.
- instr  output  32  latched instruction.
- instr_valid  output  1  instr corresponds to pc_out.
- err  output  1  sticky fault flag.
- err_code  output  2  01 misaligned PC, 10 fetch timeout, 00 none.

Behaviour:
- Reset: on a clock edge with rst_n=0, all of the following load together.
  - pc_out=RESET_PC, state=IDLE, instr=0, instr_valid=0, imem_req=0, err=0, err_code=0, counter=0.
  - Reset wins over every other input, including mid-transaction. Any response still outstanding afterwards is ignored until the next grant.
- IDLE: imem_req=0; move to REQ on the next cycle.
- REQ: imem_req=1, imem_addr=pc_out.
  - flush=1: pc_out<=flush_pc, stay in REQ. imem_gnt in this cycle is ignored, which requires memory to drop a grant that coincides with a flush.
  - Else imem_gnt=1: move to WAIT, clear the counter.
  - Else stay in REQ; the request is held with a stable address.
- WAIT: imem_req=0; the counter increments every cycle.
  - flush=1 and imem_rvalid=0: pc_out<=flush_pc, go to DRAIN.
  - flush=1 and imem_rvalid=1: drop the data, pc_out<=flush_pc, go to REQ.
  - Else imem_rvalid=1: instr<=imem_rdata, instr_valid<=1, go to HOLD.
  - Else counter reaching TIMEOUT: go to ERR with err_code=10.
- DRAIN: wait for imem_rvalid, discard the data, go to REQ. A further flush while in DRAIN only updates pc_out.
  - The timeout also applies in DRAIN.
- HOLD: instr and instr_valid are held stable.
  - flush=1: pc_out<=flush_pc, instr_valid<=0, go to REQ.
  - Else stall=1: no change.
  - Else: pc_out<=npc_in, instr_valid<=0, go to REQ.
- Alignment check: whenever a new pc_out would be loaded (from npc_in or flush_pc) with bits [1:0]!=0, the following happens together.
  - pc_out still loads that value.
  - Go to ERR with err_code=01; no request is issued.
- ERR: imem_req=0, instr_valid=0, err=1. The state is sticky until reset.
- Throughput: minimum 3 cycles per instruction (REQ, WAIT, HOLD) with single-cycle gnt and rvalid and no stall.
- pc_out changes only on leaving HOLD, on a flush, or on reset.

Test Plan:
- Reset, then gnt and rvalid each one cycle later, rdata=32'h2008_0005, npc_in=pc+4 → pc_out=0x3000, then instr_valid=1 with instr=0x20080005; after release pc_out=0x3004.
- Hold gnt low for 4 cycles in REQ → imem_req stays 1 with imem_addr=0x3000 throughout; no spurious instr_valid.
- stall=1 for 3 cycles in HOLD, npc_in=0x3010 → instr and pc_out unchanged; one cycle after stall drops, pc_out=0x3010.
- flush in WAIT with flush_pc=0x3040, rvalid 2 cycles later with rdata=0xDEAD_BEEF → data discarded, next imem_addr=0x3040, instr_valid never asserted with 0xDEADBEEF.
- npc_in=0x3006 on release from HOLD → err=1, err_code=01, imem_req=0 indefinitely; rst_n low for 1 cycle → pc_out=0x3000, err=0.
- Grant with no rvalid for 16 cycles → err_code=10. Separately, assert rst_n=0 in WAIT → IDLE; a late rvalid arriving afterwards is ignored.
